// File: rtl/serial_bridge_pkg.sv
// -----------------------------------------------------------------------------
// serial_bridge_pkg
// Shared types and helpers for the serial slave bridge: FSM state encoding,
// beat-count helpers and the {mode, addr, data} request packer.
// Ports: none (package).
// -----------------------------------------------------------------------------
package serial_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    PUSH,
    RD_REQ,
    RD_WAIT,
    SEND,
    SPLIT
  } bridge_state_e;

  // Widest request the packer can build: 1 mode bit + 64 addr + 64 data.
  localparam int unsigned PACK_MAX_W = 129;

  function automatic int unsigned beat_count(input int unsigned width, input int unsigned lane);
    return width / lane;
  endfunction

  function automatic int unsigned addr_beats(input int unsigned addr_w, input int unsigned lane);
    return beat_count(addr_w, lane);
  endfunction

  function automatic int unsigned data_beats(input int unsigned data_w, input int unsigned lane);
    return beat_count(data_w, lane);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Caller passes addr/data zero-extended; result is truncated by the caller.
  function automatic logic [PACK_MAX_W-1:0] pack_req(input logic m, input logic [63:0] addr,
                                                     input logic [63:0] data,
                                                     input int unsigned addr_w,
                                                     input int unsigned data_w);
    return (PACK_MAX_W'(m) << (addr_w + data_w)) | (PACK_MAX_W'(addr) << data_w) |
           PACK_MAX_W'(data);
  endfunction

endpackage

// File: rtl/bridge_wr_fifo.sv
// -----------------------------------------------------------------------------
// bridge_wr_fifo
// Posted-write FIFO with registered storage and a first-word fall-through head.
// Ports: clk, rst (async active-high), push/din (write), pop (read),
//        dout (current head), full, empty.
// -----------------------------------------------------------------------------
module bridge_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("bridge_wr_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] r_mem[DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign dout   = r_mem[r_rd_ptr];
  assign w_pop  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_push = push && (!full || w_pop);

  // Storage, pointers (wrap naturally: depth is a power of two) and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serial_slave_bridge.sv
// -----------------------------------------------------------------------------
// serial_slave_bridge
// Bus-side slave bridge: deserialises address/write-data beats, buffers posted
// writes in bridge_wr_fifo, issues in-order reads behind pending writes and
// serialises read data back onto the bus.
// Optional feature macro: SLAVE_BRIDGE_SPLIT_EN (split reads via SPLIT state).
// Ports:
//   clk, rst                  clock, async active-high reset
//   mode, wr_bus, master_valid master request side (1=write), MSB-first beats
//   slave_ready               bridge accepts wr_bus beats
//   rd_bus, slave_valid, master_ready  read-data beats back to the master
//   split                     read split in progress (0 without the macro)
//   req_valid, req_ready, req_out      parallel {mode, addr, data} request
//   rsp_valid, rsp_data       single-cycle read response
// -----------------------------------------------------------------------------
module serial_slave_bridge
  import serial_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned LANE_WIDTH    = 1,
  parameter int unsigned WR_FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mode,
  input  logic [LANE_WIDTH-1:0]            wr_bus,
  input  logic                             master_valid,
  input  logic                             master_ready,
  output logic [LANE_WIDTH-1:0]            rd_bus,
  output logic                             slave_ready,
  output logic                             slave_valid,
  output logic                             split,
  output logic                             req_valid,
  input  logic                             req_ready,
  output logic [ADDR_WIDTH+DATA_WIDTH:0]   req_out,
  input  logic                             rsp_valid,
  input  logic [DATA_WIDTH-1:0]            rsp_data
);

  localparam int unsigned AB    = addr_beats(ADDR_WIDTH, LANE_WIDTH);
  localparam int unsigned DB    = data_beats(DATA_WIDTH, LANE_WIDTH);
  localparam int unsigned CNT_W = $clog2(max_u(AB, DB) + 1);
  localparam int unsigned REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  if (((ADDR_WIDTH % LANE_WIDTH) != 0) || ((DATA_WIDTH % LANE_WIDTH) != 0)) begin : g_bad_lane
    $error("serial_slave_bridge: LANE_WIDTH must divide ADDR_WIDTH and DATA_WIDTH");
  end

  bridge_state_e         r_state;
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_rd_req;
  logic                  r_slave_ready;
  logic                  r_slave_valid;
  logic [LANE_WIDTH-1:0] r_rd_bus;

  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [DATA_WIDTH-1:0] w_data_next;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [REQ_W-1:0]      w_fifo_din;
  logic [REQ_W-1:0]      w_fifo_dout;
  logic [REQ_W-1:0]      w_rd_req;
  logic                  w_fifo_push;
  logic                  w_fifo_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  // MSB-first shift-in: new beat enters at the bottom, oldest bits move up.
  assign w_addr_next  = ADDR_WIDTH'({r_addr, wr_bus});
  assign w_data_next  = DATA_WIDTH'({r_data, wr_bus});
  assign w_shift_next = r_shift << LANE_WIDTH;

  assign w_fifo_din  = REQ_W'(pack_req(1'b1, 64'(r_addr), 64'(r_data), ADDR_WIDTH, DATA_WIDTH));
  assign w_rd_req    = REQ_W'(pack_req(1'b0, 64'(r_addr), 64'd0, ADDR_WIDTH, DATA_WIDTH));
  assign w_fifo_push = (r_state == PUSH);
  assign w_fifo_pop  = !r_rd_req && !w_fifo_empty && req_ready;

  bridge_wr_fifo #(
    .DEPTH(WR_FIFO_DEPTH),
    .WIDTH(REQ_W)
  ) u_wr_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (w_fifo_push),
    .pop  (w_fifo_pop),
    .din  (w_fifo_din),
    .dout (w_fifo_dout),
    .full (w_fifo_full),
    .empty(w_fifo_empty)
  );

  // A read request only exists once the FIFO has drained, so the two never collide.
  assign req_valid   = r_rd_req || !w_fifo_empty;
  assign req_out     = r_rd_req ? w_rd_req : (w_fifo_empty ? '0 : w_fifo_dout);
  assign slave_ready = r_slave_ready;
  assign slave_valid = r_slave_valid;
  assign rd_bus      = r_rd_bus;

`ifdef SLAVE_BRIDGE_SPLIT_EN
  logic r_split;
  assign split = r_split;
`else
  assign split = 1'b0;
`endif

  // Bridge FSM; handshake outputs are set on the transition into each state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_mode        <= 1'b0;
      r_addr        <= '0;
      r_data        <= '0;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_rd_req      <= 1'b0;
      r_slave_ready <= 1'b0;
      r_slave_valid <= 1'b0;
      r_rd_bus      <= '0;
`ifdef SLAVE_BRIDGE_SPLIT_EN
      r_split       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (master_valid && !(mode && w_fifo_full)) begin
            r_state       <= ADDR;
            r_mode        <= mode;
            r_cnt         <= '0;
            r_slave_ready <= 1'b1;
          end
        end
        ADDR: begin
          if (!master_valid) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_slave_ready <= 1'b0;
          end else begin
            r_addr <= w_addr_next;
            if (r_cnt == CNT_W'(AB - 1)) begin
              r_cnt <= '0;
              if (r_mode) begin
                r_state <= DATA;
              end else begin
                r_state       <= RD_REQ;
                r_slave_ready <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (!master_valid) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_slave_ready <= 1'b0;
          end else begin
            r_data <= w_data_next;
            if (r_cnt == CNT_W'(DB - 1)) begin
              r_state       <= PUSH;
              r_cnt         <= '0;
              r_slave_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        PUSH: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        RD_REQ: begin
          // Hold off until every earlier posted write has left the FIFO.
          if (!r_rd_req) begin
            if (w_fifo_empty) r_rd_req <= 1'b1;
          end else if (req_ready) begin
            r_rd_req <= 1'b0;
            r_state  <= RD_WAIT;
            r_cnt    <= '0;
          end
        end
        RD_WAIT: begin
          if (rsp_valid) begin
            r_state       <= SEND;
            r_cnt         <= '0;
            r_shift       <= rsp_data;
            r_rd_bus      <= rsp_data[DATA_WIDTH-1 -: LANE_WIDTH];
            r_slave_valid <= 1'b1;
          end
`ifdef SLAVE_BRIDGE_SPLIT_EN
          else begin
            r_state <= SPLIT;
            r_cnt   <= '0;
            r_split <= 1'b1;
          end
`endif
        end
`ifdef SLAVE_BRIDGE_SPLIT_EN
        SPLIT: begin
          if (rsp_valid) begin
            r_state       <= SEND;
            r_cnt         <= '0;
            r_shift       <= rsp_data;
            r_rd_bus      <= rsp_data[DATA_WIDTH-1 -: LANE_WIDTH];
            r_slave_valid <= 1'b1;
            r_split       <= 1'b0;
          end
        end
`endif
        SEND: begin
          if (master_ready) begin
            if (r_cnt == CNT_W'(DB - 1)) begin
              r_state       <= IDLE;
              r_cnt         <= '0;
              r_slave_valid <= 1'b0;
              r_rd_bus      <= '0;
            end else begin
              r_shift  <= w_shift_next;
              r_rd_bus <= w_shift_next[DATA_WIDTH-1 -: LANE_WIDTH];
              r_cnt    <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
